mmio_bus_ctrl: RTL

Parametrised memory-mapped I/O bus controller between the MIPS core's data port and N peripheral slots (slot 0 = data memory). Decodes a configurable address byte-field against per-slot page numbers. Runs each access as a registered transaction with a device acknowledge handshake. Returns read data, a ready pulse and a bus-error flag for unmapped or timed-out accesses.

---
 rtl/mmio_bus_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/mmio_bus_ctrl.sv
// MMIO bus controller: decodes a CPU access onto one of N_DEV slots and runs a registered
// strobe/ack transaction. Optional ACCESS timeout is enabled by defining MMIO_TIMEOUT_EN.
module mmio_bus_ctrl #(
    parameter int                       ADDR_W   = 32,
    parameter int                       DATA_W   = 32,
    parameter int                       N_DEV    = 3,
    parameter int                       SEL_LO   = 8,
    parameter int                       SEL_W    = 8,
    parameter logic [N_DEV*SEL_W-1:0]   DEV_PAGE = {8'h09, 8'h08, 8'h00},
    parameter int                       TIMEOUT  = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      err,
    output logic [N_DEV-1:0]          dev_we,
    output logic [N_DEV-1:0]          dev_re,
    output logic [ADDR_W-1:0]         dev_addr,
    output logic [DATA_W-1:0]         dev_wdata,
    input  logic [N_DEV*DATA_W-1:0]   dev_rdata,
    input  logic [N_DEV-1:0]          dev_ack
);

    localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    if (N_DEV < 1 || N_DEV > 8 || TIMEOUT < 1) begin : g_bad_cfg
        $error("mmio_bus_ctrl: N_DEV must be 1..8 and TIMEOUT at least 1");
    end

    state_t              r_state;
    logic [IDX_W-1:0]    r_sel;
    logic                r_we;

    logic [SEL_W-1:0]    w_page;
    logic                w_hit;
    logic [IDX_W-1:0]    w_sel;
    logic [N_DEV-1:0]    w_onehot;
    logic                w_ack;
    logic                w_expire;
    logic [DATA_W-1:0]   w_rdata_sel;

    assign w_page = addr[SEL_LO +: SEL_W];

    // Scan from the top slot down so the lowest matching index is the one kept.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if (w_page == DEV_PAGE[i*SEL_W +: SEL_W]) begin
                w_hit = 1'b1;
                w_sel = IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_onehot    = '0;
        w_ack       = 1'b0;
        w_rdata_sel = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (w_sel == IDX_W'(i)) begin
                w_onehot[i] = 1'b1;
            end
            if (r_sel == IDX_W'(i)) begin
                w_ack       = dev_ack[i];
                w_rdata_sel = dev_rdata[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef MMIO_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_cnt;

    // Expire on the TIMEOUT-th unacknowledged ACCESS cycle; an ack in that cycle still wins.
    assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == S_ACCESS && !w_ack) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= '0;
            r_we      <= 1'b0;
            rdata     <= '0;
            ready     <= 1'b0;
            err       <= 1'b0;
            dev_we    <= '0;
            dev_re    <= '0;
            dev_addr  <= '0;
            dev_wdata <= '0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        dev_addr  <= addr;
                        dev_wdata <= wdata;
                        r_we      <= we;
                        if (w_hit) begin
                            r_sel   <= w_sel;
                            dev_we  <= we ? w_onehot : '0;
                            dev_re  <= we ? '0 : w_onehot;
                            r_state <= S_ACCESS;
                        end else begin
                            rdata   <= '0;
                            err     <= 1'b1;
                            ready   <= 1'b1;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_ACCESS: begin
                    if (w_ack) begin
                        rdata   <= r_we ? '0 : w_rdata_sel;
                        err     <= 1'b0;
                        ready   <= 1'b1;
                        dev_we  <= '0;
                        dev_re  <= '0;
                        r_state <= S_RESP;
                    end else if (w_expire) begin
                        rdata   <= '0;
                        err     <= 1'b1;
                        ready   <= 1'b1;
                        dev_we  <= '0;
                        dev_re  <= '0;
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
